t_ff_updown_counter: RTL and testbench

//   Parametrised up/down/load counter built from a bank of T flip-flops, one per bit.

---
 rtl/t_ff_pkg.sv | 17 +
 rtl/t_ff_cell.sv | 32 +++
 rtl/t_ff_updown_counter.sv | 118 +++++++++++
 tb/tb_t_ff_updown_counter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/t_ff_pkg.sv
// Shared definitions for the T-flip-flop counter family: mode encodings and parameter helpers.
// Latency: none (types and constants only). Backpressure: not applicable.
package t_ff_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DOWN = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  // Largest count a WIDTH-bit register can hold; valid for WIDTH up to 31.
  function automatic int max_for_width(input int width);
    return (2 ** width) - 1;
  endfunction

endpackage

// File: rtl/t_ff_cell.sv
// Single T flip-flop with synchronous active-low reset; t=1 toggles q on the rising edge.
// Latency: one clock from t to q. Backpressure: none, the cell accepts t on every edge.
module t_ff_cell (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q,
  output logic qb
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    if (t) begin
      q_d = ~q_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q  = q_q;
  assign qb = ~q_q;

endmodule

// File: rtl/t_ff_updown_counter.sv
// Mod-(MAX_COUNT+1) up/down/load counter built from one T flip-flop per bit, with tc and wrap flags.
// Latency: one clock to q/wrap, tc is combinational. Backpressure: none, en gates every edge.
module t_ff_updown_counter
  import t_ff_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = (2 ** WIDTH) - 1,
  parameter bit SATURATE  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             tc,
  output logic             wrap
);

  if ((WIDTH < 1) || (MAX_COUNT < 1) || (MAX_COUNT > max_for_width(WIDTH))) begin : g_bad_params
    $error("t_ff_updown_counter: MAX_COUNT must lie in 1 .. 2**WIDTH-1");
  end

  // Limits compared one bit wider than the register so MAX_COUNT = 2**WIDTH-1 cannot alias.
  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH + 1)'(MAX_COUNT);
  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] ONE_Q   = WIDTH'(1);

  mode_e            mode_s;
  logic [WIDTH:0]   q_ext;
  logic [WIDTH:0]   load_ext;
  logic [WIDTH-1:0] next_q;
  logic [WIDTH-1:0] t_vec;
  logic [WIDTH-1:0] q_vec;
  logic [WIDTH-1:0] qb_vec;
  logic             at_max;
  logic             at_zero;
  logic             wrap_d;
  logic             wrap_q;

  assign mode_s   = mode_e'(mode);
  assign q_ext    = {1'b0, q_vec};
  assign load_ext = {1'b0, load_val};
  assign at_max   = (q_ext == MAX_EXT);
  assign at_zero  = (q_vec == '0);

  // Increments and decrements only happen strictly inside the limits, so WIDTH bits never overflow.
  always_comb begin
    next_q = q_vec;
    wrap_d = 1'b0;
    if (en) begin
      case (mode_s)
        MODE_UP: begin
          if (q_ext > MAX_EXT) begin
            next_q = '0;
          end else if (at_max) begin
            if (SATURATE) begin
              next_q = MAX_Q;
            end else begin
              next_q = '0;
              wrap_d = 1'b1;
            end
          end else begin
            next_q = q_vec + ONE_Q;
          end
        end
        MODE_DOWN: begin
          if (q_ext > MAX_EXT) begin
            next_q = MAX_Q;
          end else if (at_zero) begin
            if (SATURATE) begin
              next_q = '0;
            end else begin
              next_q = MAX_Q;
              wrap_d = 1'b1;
            end
          end else begin
            next_q = q_vec - ONE_Q;
          end
        end
        MODE_LOAD: begin
          next_q = (load_ext > MAX_EXT) ? MAX_Q : load_val;
        end
        default: begin
          next_q = q_vec;
        end
      endcase
    end
  end

  // Every transition, loads and wraps included, is expressed as a per-bit toggle mask.
  assign t_vec = q_vec ^ next_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    t_ff_cell u_cell (
      .clk (clk),
      .rst (rst),
      .t   (t_vec[i]),
      .q   (q_vec[i]),
      .qb  (qb_vec[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign q    = q_vec;
  assign qb   = qb_vec;
  assign wrap = wrap_q;
  assign tc   = en & (((mode_s == MODE_UP) & at_max) | ((mode_s == MODE_DOWN) & at_zero));

endmodule

// File: tb/tb_t_ff_updown_counter.sv
// Bench for t_ff_updown_counter: wrap (9), saturate (9) and 8-bit (255) instances against an arithmetic model.
module tb_t_ff_updown_counter;

  logic       clk = 1'b0;
  logic       rst, en;
  logic [1:0] mode;
  logic [3:0] ld;
  logic       rst_w, en_w;
  logic [1:0] mode_w;
  logic [7:0] ld_w;

  logic [3:0] qa, qba, qs, qbs;
  logic       tca, wrapa, tcs, wraps;
  logic [7:0] qw, qbw;
  logic       tcw, wrapw;

  int checks = 0;
  int errors = 0;
  int ma, ms, mw;
  bit wa, ws, ww;

  always #5 clk = ~clk;

  t_ff_updown_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1'b0)) dut_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load_val(ld),
    .q(qa), .qb(qba), .tc(tca), .wrap(wrapa));

  t_ff_updown_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1'b1)) dut_s (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load_val(ld),
    .q(qs), .qb(qbs), .tc(tcs), .wrap(wraps));

  t_ff_updown_counter #(.WIDTH(8), .MAX_COUNT(255), .SATURATE(1'b0)) dut_w (
    .clk(clk), .rst(rst_w), .en(en_w), .mode(mode_w), .load_val(ld_w),
    .q(qw), .qb(qbw), .tc(tcw), .wrap(wrapw));

  // Reference: the count lives in 0..mx; crossing either end either wraps to the other end or sticks.
  function automatic int nxt(input int q, input bit e, input logic [1:0] m, input int ldv,
                             input int mx, input bit sat, output bit w);
    w = 1'b0;
    if (!e) return q;
    case (m)
      2'b01: begin
        if (q < mx) return q + 1;
        if (sat) return mx;
        w = 1'b1;
        return 0;
      end
      2'b10: begin
        if (q > 0) return q - 1;
        if (sat) return 0;
        w = 1'b1;
        return mx;
      end
      2'b11: return (ldv > mx) ? mx : ldv;
      default: return q;
    endcase
  endfunction

  function automatic bit tc_m(input int q, input bit e, input logic [1:0] m, input int mx);
    return e && ((m == 2'b01 && q == mx) || (m == 2'b10 && q == 0));
  endfunction

  // One rising edge: advance all models, then return to the falling edge to sample and drive.
  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      ma = 0; ms = 0; wa = 0; ws = 0;
    end else begin
      ma = nxt(ma, en, mode, int'(ld), 9, 1'b0, wa);
      ms = nxt(ms, en, mode, int'(ld), 9, 1'b1, ws);
    end
    if (!rst_w) begin
      mw = 0; ww = 0;
    end else begin
      mw = nxt(mw, en_w, mode_w, int'(ld_w), 255, 1'b0, ww);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; mode = 2'b01; ld = 4'd0;
    tick();
    tick();
    checks++; if (qa !== 4'd0) begin errors++; $display("FAIL reset_q got %0d exp 0", qa); end
    checks++; if (qba !== 4'hF) begin errors++; $display("FAIL reset_qb got %h exp f", qba); end
    checks++; if (wrapa !== 1'b0) begin errors++; $display("FAIL reset_wrap got %b exp 0", wrapa); end
    checks++; if (tca !== 1'b0) begin errors++; $display("FAIL reset_tc got %b exp 0", tca); end
    checks++; if (qs !== 4'd0) begin errors++; $display("FAIL reset_q_sat got %0d exp 0", qs); end
    rst = 1'b1;
    tick();
    checks++; if (qa !== 4'd1) begin errors++; $display("FAIL reset_release got %0d exp 1", qa); end
  endtask

  task automatic test_up_wrap();
    int exp_q[11] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1};
    int pulses = 0;
    rst = 1'b0; tick(); rst = 1'b1; en = 1'b1; mode = 2'b01;
    for (int i = 0; i < 11; i++) begin
      #1;
      checks++;
      if (tca !== (ma == 9)) begin errors++; $display("FAIL up_tc step %0d got %b exp %b", i, tca, ma == 9); end
      tick();
      checks++;
      if (qa !== 4'(exp_q[i])) begin errors++; $display("FAIL up_q step %0d got %0d exp %0d", i, qa, exp_q[i]); end
      checks++;
      if (wrapa !== (i == 9)) begin errors++; $display("FAIL up_wrap step %0d got %b exp %b", i, wrapa, i == 9); end
      if (wrapa === 1'b1) pulses++;
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL up_wrap_count got %0d exp 1", pulses); end
  endtask

  task automatic test_down_wrap();
    int exp_a[4] = '{1, 0, 9, 8};
    int exp_s[4] = '{1, 0, 0, 0};
    en = 1'b1; mode = 2'b11; ld = 4'd2;
    tick();
    checks++; if (qa !== 4'd2 || qs !== 4'd2) begin errors++; $display("FAIL down_load got %0d/%0d exp 2/2", qa, qs); end
    mode = 2'b10;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (tcs !== (ms == 0)) begin errors++; $display("FAIL down_tc_sat step %0d got %b exp %b", i, tcs, ms == 0); end
      tick();
      checks++;
      if (qa !== 4'(exp_a[i])) begin errors++; $display("FAIL down_q step %0d got %0d exp %0d", i, qa, exp_a[i]); end
      checks++;
      if (wrapa !== (i == 2)) begin errors++; $display("FAIL down_wrap step %0d got %b exp %b", i, wrapa, i == 2); end
      checks++;
      if (qs !== 4'(exp_s[i]) || wraps !== 1'b0) begin
        errors++; $display("FAIL down_sat step %0d got q=%0d wrap=%b exp q=%0d wrap=0", i, qs, wraps, exp_s[i]);
      end
    end
  endtask

  task automatic test_load_clamp();
    en = 1'b1; mode = 2'b11; ld = 4'd7;
    tick();
    checks++; if (qa !== 4'd7) begin errors++; $display("FAIL load_7 got %0d exp 7", qa); end
    ld = 4'd13;
    #1;
    checks++; if (tca !== 1'b0) begin errors++; $display("FAIL load_tc got %b exp 0", tca); end
    tick();
    checks++; if (qa !== 4'd9 || qs !== 4'd9) begin errors++; $display("FAIL load_clamp got %0d/%0d exp 9/9", qa, qs); end
    en = 1'b0; ld = 4'd3;
    tick();
    checks++; if (qa !== 4'd9) begin errors++; $display("FAIL load_en0 got %0d exp 9", qa); end
    mode = 2'b01;
    #1;
    checks++; if (tca !== 1'b0) begin errors++; $display("FAIL tc_en0 got %b exp 0", tca); end
  endtask

  task automatic test_mode_change();
    int exp_q[4] = '{1, 0, 1, 0};
    rst = 1'b0; tick(); rst = 1'b1; en = 1'b1; mode = 2'b01;
    repeat (5) tick();
    checks++; if (qa !== 4'd5) begin errors++; $display("FAIL mid_up got %0d exp 5", qa); end
    rst = 1'b0;
    tick();
    checks++; if (qa !== 4'd0 || wrapa !== 1'b0) begin errors++; $display("FAIL mid_reset got q=%0d wrap=%b exp q=0 wrap=0", qa, wrapa); end
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mode = (i % 2 == 0) ? 2'b01 : 2'b10;
      tick();
      checks++;
      if (qa !== 4'(exp_q[i])) begin errors++; $display("FAIL alt step %0d got %0d exp %0d", i, qa, exp_q[i]); end
    end
    mode = 2'b00;
    repeat (3) tick();
    checks++; if (qa !== 4'd0 || wrapa !== 1'b0) begin errors++; $display("FAIL hold got q=%0d wrap=%b exp q=0 wrap=0", qa, wrapa); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      rst  = ($urandom_range(0, 31) != 0);
      en   = ($urandom_range(0, 7) != 0);
      mode = 2'($urandom_range(0, 3));
      ld   = 4'($urandom_range(0, 15));
      #1;
      checks++;
      if (tca !== tc_m(ma, en, mode, 9) || tcs !== tc_m(ms, en, mode, 9)) begin
        errors++; $display("FAIL rnd_tc cycle %0d got %b/%b exp %b/%b", i, tca, tcs, tc_m(ma, en, mode, 9), tc_m(ms, en, mode, 9));
      end
      tick();
      checks++;
      if (qa !== 4'(ma) || wrapa !== wa || qba !== 4'(15 - ma)) begin
        errors++; $display("FAIL rnd_wrapcnt cycle %0d got q=%0d qb=%0d wrap=%b exp q=%0d qb=%0d wrap=%b", i, qa, qba, wrapa, ma, 15 - ma, wa);
      end
      checks++;
      if (qs !== 4'(ms) || wraps !== ws || qbs !== 4'(15 - ms)) begin
        errors++; $display("FAIL rnd_satcnt cycle %0d got q=%0d qb=%0d wrap=%b exp q=%0d qb=%0d wrap=%b", i, qs, qbs, wraps, ms, 15 - ms, ws);
      end
    end
  endtask

  task automatic test_width_sweep();
    int pulses = 0;
    int bad_qb = 0;
    rst_w = 1'b0; en_w = 1'b1; mode_w = 2'b01; ld_w = 8'd0;
    tick();
    rst_w = 1'b1;
    for (int i = 0; i < 256; i++) begin
      tick();
      if (wrapw === 1'b1) pulses++;
      if (qbw !== 8'(255 - mw)) bad_qb++;
    end
    checks++; if (qw !== 8'd0) begin errors++; $display("FAIL sweep_q got %0d exp 0", qw); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL sweep_wrap_count got %0d exp 1", pulses); end
    checks++; if (bad_qb != 0) begin errors++; $display("FAIL sweep_qb got %0d bad cycles exp 0", bad_qb); end
    mode_w = 2'b10;
    tick();
    checks++; if (qw !== 8'd255 || wrapw !== 1'b1) begin errors++; $display("FAIL sweep_down_wrap got q=%0d wrap=%b exp q=255 wrap=1", qw, wrapw); end
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; mode = 2'b00; ld = 4'd0;
    rst_w = 1'b0; en_w = 1'b0; mode_w = 2'b00; ld_w = 8'd0;
    ma = 0; ms = 0; mw = 0; wa = 0; ws = 0; ww = 0;
    @(negedge clk);
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load_clamp();
    test_mode_change();
    test_random();
    test_width_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
